// File: rtl/reg_bus_pkg.sv
// Shared definitions for the CPU register-bus initiator: FSM encoding,
// default bus address width and read-latency counter width.
package reg_bus_pkg;

  // Default register-bus address width; slaves decode the same width.
  localparam int unsigned REG_BUS_ADDR_WIDTH = 13;

  // Width of the read-latency down-counter (RD_LAT range 0..15).
  localparam int unsigned LAT_CNT_WIDTH = 4;

  // FSM encoding, kept as plain 2-bit constants for legacy tooling.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR      = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

endpackage

// File: rtl/reg_bus_master.sv
// Register-bus initiator: converts one valid/ready request at a time into a
// single cpu_wr / cpu_rd strobe cycle and returns the result on a
// valid/ready response port. Every output is a flop.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = REG_BUS_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]  ADDR_MAX   = {ADDR_WIDTH{1'b1}},
  // Cycles from cpu_rd to valid cpu_data_out; must fit LAT_CNT_WIDTH (0..15).
  parameter int unsigned            RD_LAT     = 0
) (
  input  logic                  clks,
  input  logic                  reset,
  // Request port
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  // Response port
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  // Register bus
  output logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [31:0]           cpu_data_in,
  output logic                  cpu_wr,
  output logic                  cpu_rd,
  input  logic [31:0]           cpu_data_out
);

  logic [1:0]               state;
  logic [LAT_CNT_WIDTH-1:0] lat_cnt;
  logic                     addr_oob;

  // One extra zero bit on both sides keeps the comparison meaningful even
  // when ADDR_MAX is the all-ones address (nothing is then out of range).
  assign addr_oob = ({1'b0, req_addr} > {1'b0, ADDR_MAX});

  // Request/response FSM; all outputs are registered here so none depends
  // combinationally on an input.
  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      lat_cnt     <= '0;
      req_rdy     <= 1'b0;
      rsp_vld     <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      cpu_addr    <= '0;
      cpu_data_in <= '0;
      cpu_wr      <= 1'b0;
      cpu_rd      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge values of state, req_rdy and lat_cnt.
      case (state)
        ST_IDLE: begin
          if (req_vld && req_rdy) begin
            req_rdy <= 1'b0;
            if (addr_oob) begin
              // Rejected: no strobe, bus address/data left untouched.
              rsp_vld   <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= ST_RESP;
            end else if (req_wr) begin
              cpu_addr    <= req_addr;
              cpu_data_in <= req_wdata;
              cpu_wr      <= 1'b1;
              state       <= ST_WR;
            end else begin
              cpu_addr <= req_addr;
              cpu_rd   <= 1'b1;
              lat_cnt  <= LAT_CNT_WIDTH'(RD_LAT);
              state    <= ST_RD_WAIT;
            end
          end else begin
            // Ready rises one edge after reset release and stays up in IDLE.
            req_rdy <= 1'b1;
          end
        end

        ST_WR: begin
          cpu_wr    <= 1'b0;
          rsp_vld   <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state     <= ST_RESP;
        end

        ST_RD_WAIT: begin
          // cpu_rd is a single-cycle strobe even when the slaves are slow.
          cpu_rd <= 1'b0;
          if (lat_cnt == '0) begin
            rsp_rdata <= cpu_data_out;
            rsp_err   <= 1'b0;
            rsp_vld   <= 1'b1;
            state     <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        ST_RESP: begin
          // Response fields are held until the requester takes them.
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            req_rdy <= 1'b1;
            state   <= ST_IDLE;
          end
        end

        default: begin
          state   <= ST_IDLE;
          req_rdy <= 1'b0;
          rsp_vld <= 1'b0;
          cpu_wr  <= 1'b0;
          cpu_rd  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: three instances with different read latencies
// and address limits, each with a stub slave register file. Expected
// responses are queued at request time and compared when the response shows.
`timescale 1ns/1ps
module tb_reg_bus_master;
  import reg_bus_pkg::*;

  localparam int N  = 3;
  localparam int AW = REG_BUS_ADDR_WIDTH;
  localparam int              LAT  [N] = '{0, 3, 5};
  localparam logic [AW-1:0]   AMAX [N] = '{13'h1FFF, 13'h00FF, 13'h1FFF};

  logic clks  = 1'b0;
  logic reset = 1'b1;

  logic          req_vld   [N];
  logic          req_wr    [N];
  logic [AW-1:0] req_addr  [N];
  logic [31:0]   req_wdata [N];
  logic          rsp_rdy   [N];
  wire           req_rdy   [N];
  wire           rsp_vld   [N];
  wire           rsp_err   [N];
  wire  [31:0]   rsp_rdata [N];
  wire  [AW-1:0] cpu_addr  [N];
  wire  [31:0]   cpu_data_in  [N];
  wire           cpu_wr    [N];
  wire           cpu_rd    [N];
  wire  [31:0]   cpu_data_out [N];

  always #5 clks = ~clks;

  for (genvar g = 0; g < N; g++) begin : g_dut
    reg_bus_master #(
      .ADDR_WIDTH (AW),
      .ADDR_MAX   (AMAX[g]),
      .RD_LAT     (LAT[g])
    ) u_dut (
      .clks         (clks),
      .reset        (reset),
      .req_vld      (req_vld[g]),
      .req_rdy      (req_rdy[g]),
      .req_wr       (req_wr[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .rsp_vld      (rsp_vld[g]),
      .rsp_rdy      (rsp_rdy[g]),
      .rsp_err      (rsp_err[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .cpu_addr     (cpu_addr[g]),
      .cpu_data_in  (cpu_data_in[g]),
      .cpu_wr       (cpu_wr[g]),
      .cpu_rd       (cpu_rd[g]),
      .cpu_data_out (cpu_data_out[g])
    );

    // Stub slave: 16 registers; read data is valid only in the cycle that is
    // RD_LAT cycles after the cpu_rd strobe, garbage otherwise.
    logic [31:0] stub_mem [16];
    logic [15:0] rd_hist = '0;
    logic        rd_ok;

    always @(posedge clks) begin
      if (cpu_wr[g] === 1'b1) stub_mem[cpu_addr[g][3:0]] <= cpu_data_in[g];
      rd_hist <= {rd_hist[14:0], cpu_rd[g]};
    end

    if (LAT[g] == 0) begin : g_l0
      assign rd_ok = cpu_rd[g];
    end else begin : g_ln
      assign rd_ok = rd_hist[LAT[g]-1];
    end

    assign cpu_data_out[g] = rd_ok ? stub_mem[cpu_addr[g][3:0]] : 32'hDEAD_DEAD;
  end

  typedef struct {
    logic          wr;
    logic          err;
    logic [31:0]   rdata;
    int            lat;
    logic [AW-1:0] addr_hold;
    logic [31:0]   data_hold;
  } rsp_t;

  rsp_t          sb [$];
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   model_mem  [N][16];
  logic [AW-1:0] last_addr  [N];
  logic [31:0]   last_wdata [N];

  // Present a request (optionally waiting for req_rdy) and queue its expected response.
  task automatic issue_req(input int d, input logic wr, input logic [AW-1:0] addr,
                           input logic [31:0] wdata, input bit wait_rdy);
    rsp_t e;
    int   w = 0;
    if (wait_rdy) begin
      while (req_rdy[d] !== 1'b1 && w < 20) begin
        @(negedge clks);
        w++;
      end
      checks++;
      if (req_rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL req_rdy_wait d=%0d got %b want 1", d, req_rdy[d]);
      end
    end
    req_vld[d]   = 1'b1;
    req_wr[d]    = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    e.wr  = wr;
    e.err = ({1'b0, addr} > {1'b0, AMAX[d]});
    if (!e.err) begin
      last_addr[d] = addr;
      if (wr) begin
        last_wdata[d] = wdata;
        model_mem[d][addr[3:0]] = wdata;
      end
    end
    e.rdata     = (wr || e.err) ? 32'h0 : model_mem[d][addr[3:0]];
    e.lat       = e.err ? 1 : (wr ? 2 : 2 + LAT[d]);
    e.addr_hold = last_addr[d];
    e.data_hold = last_wdata[d];
    sb.push_back(e);
  endtask

  // Follow the transaction from the accept edge until rsp_vld, then compare.
  task automatic collect_rsp(input int d, input string name);
    rsp_t e;
    int   cyc = 0, n_wr = 0, n_rd = 0, n_both = 0, n_rdy = 0;
    bit   strobe_ok = 1'b1;
    int   exp_wr, exp_rd;
    do begin
      @(negedge clks);
      cyc++;
      if (cyc == 1) req_vld[d] = 1'b0;
      if (cpu_wr[d] === 1'b1) n_wr++;
      if (cpu_rd[d] === 1'b1) n_rd++;
      if (cpu_wr[d] === 1'b1 && cpu_rd[d] === 1'b1) n_both++;
      if (req_rdy[d] !== 1'b0) n_rdy++;
      if ((cpu_wr[d] === 1'b1 || cpu_rd[d] === 1'b1) &&
          (cpu_addr[d] !== last_addr[d])) strobe_ok = 1'b0;
    end while (rsp_vld[d] !== 1'b1 && cyc < 40);

    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty d=%0d", name, d);
      return;
    end
    e = sb.pop_front();
    exp_wr = (e.wr && !e.err) ? 1 : 0;
    exp_rd = (!e.wr && !e.err) ? 1 : 0;

    if (cyc != e.lat) begin
      errors++;
      $display("FAIL %s latency d=%0d got %0d want %0d", name, d, cyc, e.lat);
    end
    checks++;
    if (rsp_err[d] !== e.err || rsp_rdata[d] !== e.rdata) begin
      errors++;
      $display("FAIL %s response d=%0d got err=%b rdata=%h want err=%b rdata=%h",
               name, d, rsp_err[d], rsp_rdata[d], e.err, e.rdata);
    end
    checks++;
    if (n_wr != exp_wr || n_rd != exp_rd || n_both != 0 || !strobe_ok) begin
      errors++;
      $display("FAIL %s strobes d=%0d got wr=%0d rd=%0d both=%0d addr_ok=%0d want wr=%0d rd=%0d",
               name, d, n_wr, n_rd, n_both, strobe_ok, exp_wr, exp_rd);
    end
    checks++;
    if (n_rdy != 0) begin
      errors++;
      $display("FAIL %s req_rdy_busy d=%0d got %0d cycles high want 0", name, d, n_rdy);
    end
    checks++;
    if (cpu_addr[d] !== e.addr_hold || cpu_data_in[d] !== e.data_hold) begin
      errors++;
      $display("FAIL %s bus_hold d=%0d got addr=%h data=%h want addr=%h data=%h",
               name, d, cpu_addr[d], cpu_data_in[d], e.addr_hold, e.data_hold);
    end
    if (rsp_rdy[d] === 1'b1) begin
      @(negedge clks);
      checks++;
      if (rsp_vld[d] !== 1'b0 || req_rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL %s handshake d=%0d got rsp_vld=%b req_rdy=%b want 0 1",
                 name, d, rsp_vld[d], req_rdy[d]);
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < N; d++) begin
      req_vld[d] = 1'b0; req_wr[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; rsp_rdy[d] = 1'b1;
      last_addr[d] = '0; last_wdata[d] = '0;
    end
    reset = 1'b1;
    repeat (5) @(negedge clks);
    for (int d = 0; d < N; d++) begin
      checks++;
      if (req_rdy[d] !== 1'b0 || rsp_vld[d] !== 1'b0 || rsp_err[d] !== 1'b0 ||
          rsp_rdata[d] !== 32'h0 || cpu_addr[d] !== '0 || cpu_data_in[d] !== 32'h0 ||
          cpu_wr[d] !== 1'b0 || cpu_rd[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_values d=%0d got rdy=%b vld=%b err=%b rdata=%h addr=%h din=%h wr=%b rd=%b want all 0",
                 d, req_rdy[d], rsp_vld[d], rsp_err[d], rsp_rdata[d], cpu_addr[d],
                 cpu_data_in[d], cpu_wr[d], cpu_rd[d]);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rdy_before_edge got %b want 0", req_rdy[0]);
    end
    @(negedge clks);
    for (int d = 0; d < N; d++) begin
      checks++;
      if (req_rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL rdy_after_release d=%0d got %b want 1", d, req_rdy[d]);
      end
    end
  endtask

  task automatic test_write();
    issue_req(0, 1'b1, 13'h0010, 32'hA5A5_0001, 1'b1);
    collect_rsp(0, "write");
    issue_req(0, 1'b0, 13'h0010, 32'h0, 1'b1);
    collect_rsp(0, "write_readback");
  endtask

  task automatic test_read();
    for (int d = 0; d < 2; d++) begin
      issue_req(d, 1'b1, 13'h0005, 32'h0000_BEEF, 1'b1);
      collect_rsp(d, "read_setup");
      issue_req(d, 1'b0, 13'h0005, 32'h0, 1'b1);
      collect_rsp(d, (d == 0) ? "read_lat0" : "read_lat3");
    end
  endtask

  task automatic test_out_of_range();
    issue_req(1, 1'b1, 13'h0100, 32'hFFFF_0000, 1'b1);
    collect_rsp(1, "oob_write");
    issue_req(1, 1'b0, 13'h1FFF, 32'h0, 1'b1);
    collect_rsp(1, "oob_read_top");
    issue_req(1, 1'b1, 13'h00FF, 32'h1234_5678, 1'b1);
    collect_rsp(1, "edge_write");
    issue_req(1, 1'b0, 13'h00FF, 32'h0, 1'b1);
    collect_rsp(1, "edge_read");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 15));
      issue_req(0, 1'b1, a, $urandom, 1'b1);
      collect_rsp(0, "b2b_write");
      issue_req(0, 1'b0, a, 32'h0, 1'b1);
      collect_rsp(0, "b2b_read");
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_rdata;
    exp_rdata = model_mem[1][5];
    rsp_rdy[1] = 1'b0;
    issue_req(1, 1'b0, 13'h0005, 32'h0, 1'b1);
    collect_rsp(1, "bp_read");
    // A second request waits while the response is stalled.
    issue_req(1, 1'b1, 13'h0006, 32'hC0DE_0006, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clks);
      checks++;
      if (rsp_vld[1] !== 1'b1 || rsp_rdata[1] !== exp_rdata || req_rdy[1] !== 1'b0 ||
          cpu_wr[1] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got vld=%b rdata=%h rdy=%b wr=%b want 1 %h 0 0",
                 i, rsp_vld[1], rsp_rdata[1], req_rdy[1], cpu_wr[1], exp_rdata);
      end
    end
    rsp_rdy[1] = 1'b1;
    @(negedge clks);
    checks++;
    if (rsp_vld[1] !== 1'b0 || req_rdy[1] !== 1'b1 || cpu_wr[1] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b wr=%b want 0 1 0",
               rsp_vld[1], req_rdy[1], cpu_wr[1]);
    end
    collect_rsp(1, "bp_queued_write");
  endtask

  task automatic test_reset_mid_read();
    int late_vld = 0;
    issue_req(2, 1'b1, 13'h0005, 32'h5A5A_0002, 1'b1);
    collect_rsp(2, "mid_setup");
    issue_req(2, 1'b0, 13'h0005, 32'h0, 1'b1);
    @(negedge clks);
    req_vld[2] = 1'b0;
    repeat (2) @(negedge clks);
    reset = 1'b1;
    #1;
    checks++;
    if (cpu_addr[2] !== '0 || cpu_rd[2] !== 1'b0 || rsp_vld[2] !== 1'b0 ||
        req_rdy[2] !== 1'b0 || cpu_data_in[2] !== 32'h0 || rsp_rdata[2] !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_async got addr=%h rd=%b vld=%b rdy=%b din=%h rdata=%h want all 0",
               cpu_addr[2], cpu_rd[2], rsp_vld[2], req_rdy[2], cpu_data_in[2], rsp_rdata[2]);
    end
    sb.delete();
    for (int d = 0; d < N; d++) begin
      last_addr[d] = '0;
      last_wdata[d] = '0;
    end
    repeat (2) @(negedge clks);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clks);
      if (rsp_vld[2] !== 1'b0) late_vld++;
    end
    checks++;
    if (late_vld != 0) begin
      errors++;
      $display("FAIL mid_reset_no_rsp got %0d cycles of rsp_vld want 0", late_vld);
    end
    issue_req(2, 1'b0, 13'h0005, 32'h0, 1'b1);
    collect_rsp(2, "post_reset_read_lat5");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_read();
    repeat (2) @(negedge clks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule
